shift_register_univ: RTL

Parametrised universal shift register, the next generation of the team's 4-bit serial-in shift register. Supports hold, shift right, shift left and parallel load on a WIDTH-bit register with clock enable, and serial outputs at both ends. Includes a shift counter that pulses `Word_done` each time WIDTH shifts complete, so the block can serialise and deserialise whole words in the datapath without external counting.

---
 rtl/shift_register_univ_if.sv | 57 +++++
 rtl/shift_register_univ.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/shift_register_univ_if.sv
// ---------------------------------------------------------------------------
// shift_register_univ_if
//
// Bundles the control, data and status signals of shift_register_univ so a
// datapath can pass the whole shift-register port as one object. The clock
// (CLK) and reset (Reset) stay plain ports on the module.
//
// Parameters:
//   WIDTH - register width in bits (2..64); must match the attached module.
//   CW    - shift counter width, derived from WIDTH; do not override.
//
// Signals (direction as seen from the shift register, i.e. the slave):
//   En            in   clock enable
//   Mode          in   00 hold, 01 shift right, 10 shift left, 11 load
//   Rot           in   rotate select (only used in SHIFT_ROTATE_EN builds)
//   Shift_in_msb  in   serial input entering Q[WIDTH-1] on shift right
//   Shift_in_lsb  in   serial input entering Q[0] on shift left
//   Load_data     in   parallel load value
//   Q             out  register contents
//   Shift_out_lsb out  Q[0]
//   Shift_out_msb out  Q[WIDTH-1]
//   Count         out  shifts since last load, reset or wrap
//   Word_done     out  one-cycle pulse when WIDTH shifts have completed
//
// Modports:
//   master - the client that drives controls/data and observes status
//   slave  - the shift register itself
// ---------------------------------------------------------------------------
interface shift_register_univ_if #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH) + 1
);

  logic             En;
  logic [1:0]       Mode;
  logic             Rot;
  logic             Shift_in_msb;
  logic             Shift_in_lsb;
  logic [WIDTH-1:0] Load_data;

  logic [WIDTH-1:0] Q;
  logic             Shift_out_lsb;
  logic             Shift_out_msb;
  logic [CW-1:0]    Count;
  logic             Word_done;

  modport master (
    output En, Mode, Rot, Shift_in_msb, Shift_in_lsb, Load_data,
    input  Q, Shift_out_lsb, Shift_out_msb, Count, Word_done
  );

  modport slave (
    input  En, Mode, Rot, Shift_in_msb, Shift_in_lsb, Load_data,
    output Q, Shift_out_lsb, Shift_out_msb, Count, Word_done
  );

endinterface : shift_register_univ_if

// File: rtl/shift_register_univ.sv
// ---------------------------------------------------------------------------
// shift_register_univ
//
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load on a WIDTH-bit register, with clock enable and serial outputs
// at both ends. A shift counter pulses Word_done each time WIDTH shifts have
// completed, so whole words can be serialised/deserialised without an
// external counter. Shifts in either direction count alike; a load or reset
// restarts the word.
//
// Optional feature (compile-time macro SHIFT_ROTATE_EN):
//   defined     - Rot=1 turns shift right/left into rotate right/left
//                 (the bit shifted out re-enters at the other end).
//   not defined - Rot is ignored; shifts always use the serial inputs.
//
// Parameters:
//   WIDTH - register width in bits, legal range 2..64.
//   CW    - shift counter width, $clog2(WIDTH)+1; do not override.
//
// Ports:
//   CLK   in   clock, all state updates on the rising edge
//   Reset in   synchronous, active-high reset
//   bus   slave modport of shift_register_univ_if (see that file for the
//         individual control, data and status signals)
//
// Priority: Reset, then En=0, then Mode. All outputs are registers or direct
// wires from registers; latency from any input to Q/Count/Word_done is one
// cycle.
// ---------------------------------------------------------------------------
module shift_register_univ #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input logic                  CLK,
  input logic                  Reset,
  shift_register_univ_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;
  logic             word_done;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  mode_e mode;
  assign mode = mode_e'(bus.Mode);

  // The word is complete when this shift is the WIDTH-th since the last
  // restart, i.e. the counter currently reads WIDTH-1.
  logic last_shift;
  assign last_shift = (count == CW'(WIDTH - 1));

  logic [CW-1:0] count_inc;
  assign count_inc = last_shift ? '0 : count + CW'(1);

  // -------------------------------------------------------------------------
  // Serial-in selection
  // -------------------------------------------------------------------------
  logic shr_in;   // bit entering q[WIDTH-1] on a right shift
  logic shl_in;   // bit entering q[0] on a left shift

  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    shr_in = bus.Shift_in_msb;
    shl_in = bus.Shift_in_lsb;
`ifdef SHIFT_ROTATE_EN
    // Rotating feeds the bit falling off one end back into the other.
    if (bus.Rot) begin
      shr_in = q[0];
      shl_in = q[WIDTH-1];
    end
`endif
  end

`ifndef SHIFT_ROTATE_EN
  // Rot is part of the port list in every build but has no function here.
  logic unused_rot;
  assign unused_rot = bus.Rot;
`endif

  // -------------------------------------------------------------------------
  // Register, counter and word pulse
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every right-hand side sees the pre-edge value of q/count regardless of
  // statement order.
  always_ff @(posedge CLK) begin
    // NOTE: Reset is sampled on the clock edge (synchronous), hence it is not
    // in the sensitivity list.
    if (Reset) begin
      q         <= '0;
      count     <= '0;
      word_done <= 1'b0;
    end else if (!bus.En) begin
      // State holds; the pulse is dropped so it is never stretched.
      word_done <= 1'b0;
    end else begin
      unique case (mode)
        MODE_HOLD: begin
          word_done <= 1'b0;
        end
        MODE_SHR: begin
          q         <= {shr_in, q[WIDTH-1:1]};
          count     <= count_inc;
          word_done <= last_shift;
        end
        MODE_SHL: begin
          q         <= {q[WIDTH-2:0], shl_in};
          count     <= count_inc;
          word_done <= last_shift;
        end
        MODE_LOAD: begin
          // A load starts a fresh word, exactly like reset for the counter.
          q         <= bus.Load_data;
          count     <= '0;
          word_done <= 1'b0;
        end
        default: begin
          word_done <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: straight from the registers, no added latency
  // -------------------------------------------------------------------------
  assign bus.Q             = q;
  assign bus.Shift_out_lsb = q[0];
  assign bus.Shift_out_msb = q[WIDTH-1];
  assign bus.Count         = count;
  assign bus.Word_done     = word_done;

endmodule : shift_register_univ
